keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Drives a 4x4 active-low matrix keypad plus a dedicated lock button.
//   Scans, debounces and encodes presses into the 5-bit keyout code consumed by the lock fsm.
//   Emits exactly one single-cycle code per debounced press; KEY_NONE at all other times.
//   Sits between the board keypad pins and fsm.keyout.
// PARAMETERS
//   SCAN_DIV        16   clk cycles each column is driven low (>=2)
//   DEBOUNCE_FRAMES 4    consecutive identical scan frames required for press and for release (>=1)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  reset, asynchronous, active-low
//   row_n     in   4  keypad rows; 0 = key in active column closed
//   lock_btn  in   1  lock button, active-high
//   col_n     out  4  keypad column drive, one-cold
//   keyout    out  5  0..15 = matrix key, 16 = KEY_LOCK, 31 = KEY_NONE
//   key_down  out  1  high from emit cycle until debounced release
// BEHAVIOUR
//   Reset, asynchronous (rst=0):
//     col_n=4'b1110, keyout=KEY_NONE, key_down=0, state S_IDLE, all counters 0.
//   Column scan:
//     - col c is held low for SCAN_DIV cycles, then c moves to (c+1) mod 4.
//     - row_n is sampled on the last cycle of each slot.
//     - Row r low while col c is active -> key code r*4+c.
//   Frame:
//     - One frame is 4 slots; frame_done pulses on the last cycle of col 3.
//     - frame_code = KEY_LOCK if lock_btn was high at any sample in the frame (lock has priority).
//     - Otherwise frame_code = the single matrix key pressed.
//     - Otherwise KEY_NONE; two or more matrix keys count as KEY_NONE (ghost reject).
//   FSM transitions (evaluated only on frame_done, except S_EMIT):
//     S_IDLE     : code!=NONE -> S_DEBOUNCE, cand=code, cnt=1.
//                  If DEBOUNCE_FRAMES==1 -> S_EMIT instead.
//     S_DEBOUNCE : code==cand -> cnt++; cnt reaching DEBOUNCE_FRAMES -> S_EMIT.
//                  code!=cand -> S_IDLE, cnt=0 (no emit).
//     S_EMIT     : one clk; keyout=cand, key_down=1 -> S_HELD, cnt=0.
//     S_HELD     : code==NONE -> cnt++; cnt reaching DEBOUNCE_FRAMES -> S_IDLE, key_down=0.
//                  code!=NONE -> cnt=0. A change K->K' without release emits nothing.
//   Outputs:
//     - keyout is registered; it equals cand only during the cycle after entry to S_EMIT,
//       otherwise KEY_NONE.
//     - Latency: press stable from a frame start -> emit DEBOUNCE_FRAMES frames + 1 clk later.
//   Reset mid-scan or mid-emit aborts immediately: no partial or late code is emitted.
//   Counter widths: $clog2(SCAN_DIV), $clog2(DEBOUNCE_FRAMES+1); no wrap beyond terminal value.
// CONFIGURATION
//   KEYPAD_SYNC_EN defined:
//     row_n and lock_btn pass through 2-flop synchronizers (reset to 1/0).
//     Sampling sees pin state 2 clks late; slot sample point is unchanged.
//   KEYPAD_SYNC_EN undefined:
//     row_n and lock_btn are sampled directly (sim / already-synchronous sources).
// STRUCTURE
//   lock_pkg (shared with fsm):
//     - KEY_LOCK=5'd16, KEY_NONE=5'd31, key code typedef.
//     - scanner state enum {S_IDLE,S_DEBOUNCE,S_EMIT,S_HELD}.
//   Sub-module keypad_col_scan:
//     - column counter, slot divider, row sampling, ghost detect.
//     - outputs frame_code and frame_done.
//   Top: debounce FSM and output registers.
// TESTING (SCAN_DIV=2, DEBOUNCE_FRAMES=3 -> 8-clk frame)
//   1. rst low while key 6 held in S_DEBOUNCE -> same instant keyout=31, col_n=1110, key_down=0;
//      after rst high, a fresh 3-frame debounce is required.
//   2. row1 low during col2 for 6 frames then released -> keyout=6 for exactly 1 clk;
//      key_down high until 3 NONE frames pass.
//   3. key 3 held 2 frames then released (bounce) -> keyout stays 31 throughout, key_down=0.
//   4. lock_btn=1 with key 5 held 4 frames -> single keyout=16; matrix key ignored.
//   5. keys 0 and 5 held together -> no emit.
//      Slide key 1 -> key 2 without release -> only 1 emitted.
//   6. Connected to fsm with seq=32'h12345678, pulse lock -> LS0.
//      Press 1..8 with releases -> OPEN; press lock -> LS0.

Source files
------------

// File: rtl/lock_pkg.sv
// Key codes and scanner state encoding shared by the keypad scanner and the lock fsm.
package lock_pkg;

  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_LOCK = 5'd16;
  localparam key_code_t KEY_NONE = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_EMIT, S_HELD} scan_state_t;

  // Matrix keys are numbered row-major: row*4 + col.
  function automatic key_code_t matrix_code(input logic [1:0] row, input logic [1:0] col);
    return {1'b0, row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Board-side keypad pins plus the encoded key output, bundled for the scanner.
interface keypad_scanner_if;

  logic [3:0]          row_n;
  logic                lock_btn;
  logic [3:0]          col_n;
  lock_pkg::key_code_t keyout;
  logic                key_down;

  modport master (input row_n, lock_btn, output col_n, keyout, key_down);
  modport slave  (output row_n, lock_btn, input col_n, keyout, key_down);

endinterface

// File: rtl/keypad_scanner_col_scan.sv
// Column driver and per-frame key sampler; reports one code per 4-column frame.
// Define KEYPAD_SYNC_EN to put 2-flop synchronizers on row_n and lock_btn.
module keypad_col_scan
  import lock_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] row_n,
  input  logic      lock_btn,
  output logic [3:0] col_n,
  output key_code_t frame_code,
  output logic      frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0] row_s;
  logic       lock_s;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] row_m;
  logic       lock_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m  <= '1;
      row_s  <= '1;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      row_m  <= row_n;
      row_s  <= row_m;
      lock_m <= lock_btn;
      lock_s <= lock_m;
    end
  end
`else
  assign row_s  = row_n;
  assign lock_s = lock_btn;
`endif

  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic          slot_last;
  logic [1:0]    hits_q, hits_nx;
  logic [3:0]    key_q, key_nx;
  logic          lock_q, lock_nx;
  logic [2:0]    row_hits;
  logic [1:0]    hit_row;

  assign slot_last  = (div_q == DIV_LAST);
  assign frame_done = slot_last && (col_q == 2'd3);
  assign col_n      = ~(4'b0001 << col_q);

  // Hit count saturates at 2: anything beyond one key in a frame is a ghost.
  always_comb begin
    row_hits = '0;
    hit_row  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        row_hits = row_hits + 3'd1;
        hit_row  = 2'(r);
      end
    end
    lock_nx = lock_q | lock_s;
    key_nx  = (row_hits == 3'd1) ? {hit_row, col_q} : key_q;
    if (({1'b0, hits_q} + row_hits) >= 3'd2) hits_nx = 2'd2;
    else                                     hits_nx = hits_q + row_hits[1:0];
    if (lock_nx)              frame_code = KEY_LOCK;
    else if (hits_nx == 2'd1) frame_code = matrix_code(key_nx[3:2], key_nx[1:0]);
    else                      frame_code = KEY_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      col_q  <= '0;
      hits_q <= '0;
      key_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      div_q <= slot_last ? '0 : div_q + 1'b1;
      if (slot_last) begin
        col_q <= col_q + 2'd1;
        if (frame_done) begin
          hits_q <= '0;
          key_q  <= '0;
          lock_q <= 1'b0;
        end else begin
          hits_q <= hits_nx;
          key_q  <= key_nx;
          lock_q <= lock_nx;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad + lock button scanner: debounces frame codes and emits one keyout pulse per press.
// Define KEYPAD_SYNC_EN to synchronize row_n and lock_btn inside the column scanner.
module keypad_scanner
  import lock_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES);

  key_code_t   frame_code;
  logic        frame_done;
  scan_state_t state_q, state_d;
  key_code_t   cand_q, cand_d;
  key_code_t   keyout_q, keyout_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        key_down_q, key_down_d;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk        (clk),
    .rst        (rst),
    .row_n      (kp.row_n),
    .lock_btn   (kp.lock_btn),
    .col_n      (kp.col_n),
    .frame_code (frame_code),
    .frame_done (frame_done)
  );

  assign cnt_inc     = cnt_q + 1'b1;
  assign kp.keyout   = keyout_q;
  assign kp.key_down = key_down_q;

  // The same counter tracks matching press frames and, once held, consecutive empty frames.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    key_down_d = key_down_q;
    keyout_d   = KEY_NONE;
    case (state_q)
      S_IDLE: begin
        if (frame_done && frame_code != KEY_NONE) begin
          cand_d  = frame_code;
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE_FRAMES == 1) ? S_EMIT : S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (frame_done) begin
          if (frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) state_d = S_EMIT;
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT: begin
        keyout_d   = cand_q;
        key_down_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_HELD;
      end
      S_HELD: begin
        if (frame_done) begin
          if (frame_code != KEY_NONE) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_LAST) begin
            cnt_d      = '0;
            key_down_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cand_q     <= KEY_NONE;
      cnt_q      <= '0;
      keyout_q   <= KEY_NONE;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      keyout_q   <= keyout_d;
      key_down_q <= key_down_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model feeds the DUT, a frame-level press model predicts outputs.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 2;
  localparam int DF       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic        lock_drv = 1'b0;
  logic [3:0]  kp_rows;

  int checks = 0;
  int errors = 0;

  logic [4:0] obs_key [FRAME];
  logic [4:0] exp_key [FRAME];
  logic       obs_down[FRAME];
  logic       exp_down[FRAME];
  logic [3:0] obs_col [FRAME];
  logic [3:0] exp_col [FRAME];

  // Frame-level model of what the user has achieved: 0 idle, 1 confirming, 2 held.
  int         m_mode;
  int         m_n;
  logic [4:0] m_cand;
  logic       m_emit;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its row low while its column is driven low.
  always_comb begin
    kp_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !bus.col_n[c]) kp_rows[r] = 1'b0;
  end
  assign bus.row_n    = kp_rows;
  assign bus.lock_btn = lock_drv;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [4:0] ref_code(input logic [15:0] mask, input logic lock);
    if (lock) return 5'd16;
    if ($countones(mask) != 1) return 5'd31;
    for (int k = 0; k < 16; k++) if (mask[k]) return 5'(k);
    return 5'd31;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_n    = 0;
    m_cand = 5'd31;
    m_emit = 1'b0;
  endfunction

  function automatic void model_expect();
    logic [3:0] one = 4'b0001;
    for (int i = 0; i < FRAME; i++) begin
      exp_key[i]  = (m_emit && i == 1) ? m_cand : 5'd31;
      exp_down[i] = (m_mode == 2) && !(m_emit && i == 0);
      exp_col[i]  = ~(one << (i / SCAN_DIV));
    end
  endfunction

  function automatic void model_advance(input logic [4:0] fc);
    m_emit = 1'b0;
    if (m_mode == 0) begin
      if (fc != 5'd31) begin
        m_cand = fc;
        m_n    = 1;
        if (m_n >= DF) begin m_emit = 1'b1; m_mode = 2; m_n = 0; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (fc == m_cand) begin
        m_n++;
        if (m_n >= DF) begin m_emit = 1'b1; m_mode = 2; m_n = 0; end
      end else begin
        m_mode = 0;
        m_n    = 0;
      end
    end else begin
      if (fc == 5'd31) begin
        m_n++;
        if (m_n >= DF) begin m_mode = 0; m_n = 0; end
      end else m_n = 0;
    end
  endfunction

  // Entered and left just after the rising edge that starts a frame.
  task automatic drive_frame(input logic [15:0] mask, input logic lock);
    pressed  = mask;
    lock_drv = lock;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      obs_key[i]  = bus.keyout;
      obs_down[i] = bus.key_down;
      obs_col[i]  = bus.col_n;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (bus.col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset col_n: got %b expected 1110", bus.col_n); end
    if (bus.keyout !== 5'd31) begin errors++; $display("[TB] FAIL reset keyout: got %0d expected 31", bus.keyout); end
    if (bus.key_down !== 1'b0) begin errors++; $display("[TB] FAIL reset key_down: got %b expected 0", bus.key_down); end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_hold col_n: got %b expected 1110", bus.col_n); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    model_expect();
    drive_frame('0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      checks += 3;
      if (obs_col[i] !== exp_col[i]) begin errors++; $display("[TB] FAIL first_frame col_n c%0d: got %b expected %b", i, obs_col[i], exp_col[i]); end
      if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL first_frame keyout c%0d: got %0d expected %0d", i, obs_key[i], exp_key[i]); end
      if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL first_frame key_down c%0d: got %b expected %b", i, obs_down[i], exp_down[i]); end
    end
    model_advance(ref_code('0, 1'b0));
  endtask

  task automatic test_single_press();
    int emits = 0;
    int down_cycles = 0;
    logic [15:0] m;
    for (int f = 0; f < 10; f++) begin
      m = (f < 6) ? 16'h0040 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL press keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL press key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] == 5'd6) emits++;
        if (obs_down[i] === 1'b1) down_cycles++;
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks += 2;
    if (emits != 1) begin errors++; $display("[TB] FAIL press emit_count: got %0d expected 1", emits); end
    if (down_cycles != (FRAME - 1) + 5 * FRAME) begin
      errors++; $display("[TB] FAIL press key_down_cycles: got %0d expected %0d", down_cycles, (FRAME - 1) + 5 * FRAME);
    end
  endtask

  task automatic test_bounce();
    int emits = 0;
    logic [15:0] m;
    for (int f = 0; f < 5; f++) begin
      m = (f < 2) ? 16'h0008 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL bounce keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL bounce key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] != 5'd31) emits++;
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks++;
    if (emits != 0) begin errors++; $display("[TB] FAIL bounce emit_count: got %0d expected 0", emits); end
  endtask

  task automatic test_lock_priority();
    int lock_emits = 0;
    int emits = 0;
    logic lk;
    logic [15:0] m;
    for (int f = 0; f < 8; f++) begin
      lk = (f < 4);
      m  = (f < 4) ? 16'h0020 : 16'h0000;
      model_expect();
      drive_frame(m, lk);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL lock keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL lock key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] != 5'd31) emits++;
        if (obs_key[i] == 5'd16) lock_emits++;
      end
      model_advance(ref_code(m, lk));
    end
    checks += 2;
    if (lock_emits != 1) begin errors++; $display("[TB] FAIL lock lock_emits: got %0d expected 1", lock_emits); end
    if (emits != 1) begin errors++; $display("[TB] FAIL lock emit_count: got %0d expected 1", emits); end
  endtask

  task automatic test_ghost();
    int emits = 0;
    logic [15:0] m;
    for (int f = 0; f < 6; f++) begin
      m = (f < 5) ? 16'h0021 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL ghost keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL ghost key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] != 5'd31) emits++;
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks++;
    if (emits != 0) begin errors++; $display("[TB] FAIL ghost emit_count: got %0d expected 0", emits); end
  endtask

  task automatic test_slide();
    int emits = 0;
    logic [4:0] first_code = 5'd31;
    logic [15:0] m;
    for (int f = 0; f < 12; f++) begin
      m = (f < 4) ? 16'h0002 : (f < 8) ? 16'h0004 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL slide keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL slide key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] != 5'd31) begin emits++; first_code = obs_key[i]; end
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks += 2;
    if (emits != 1) begin errors++; $display("[TB] FAIL slide emit_count: got %0d expected 1", emits); end
    if (first_code !== 5'd1) begin errors++; $display("[TB] FAIL slide emitted_code: got %0d expected 1", first_code); end
  endtask

  task automatic test_reset_mid_debounce();
    int emits = 0;
    logic [15:0] m;
    for (int f = 0; f < 2; f++) begin
      model_expect();
      drive_frame(16'h0040, 1'b0);
      model_advance(ref_code(16'h0040, 1'b0));
    end
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (bus.col_n !== 4'b1011) begin errors++; $display("[TB] FAIL mid_debounce pre_col_n: got %b expected 1011", bus.col_n); end
    rst = 1'b0;
    #1;
    checks += 3;
    if (bus.col_n !== 4'b1110) begin errors++; $display("[TB] FAIL mid_debounce col_n: got %b expected 1110", bus.col_n); end
    if (bus.keyout !== 5'd31) begin errors++; $display("[TB] FAIL mid_debounce keyout: got %0d expected 31", bus.keyout); end
    if (bus.key_down !== 1'b0) begin errors++; $display("[TB] FAIL mid_debounce key_down: got %b expected 0", bus.key_down); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int f = 0; f < 9; f++) begin
      m = (f < 5) ? 16'h0040 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL rearm keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL rearm key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] == 5'd6) emits++;
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks++;
    if (emits != 1) begin errors++; $display("[TB] FAIL rearm emit_count: got %0d expected 1", emits); end
  endtask

  task automatic test_reset_mid_emit();
    int emits = 0;
    logic [15:0] m;
    for (int f = 0; f < 3; f++) begin
      model_expect();
      drive_frame(16'h0040, 1'b0);
      model_advance(ref_code(16'h0040, 1'b0));
    end
    @(posedge clk);
    #2;
    checks++;
    if (bus.keyout !== 5'd6) begin errors++; $display("[TB] FAIL mid_emit pre_keyout: got %0d expected 6", bus.keyout); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (bus.keyout !== 5'd31) begin errors++; $display("[TB] FAIL mid_emit keyout: got %0d expected 31", bus.keyout); end
    if (bus.key_down !== 1'b0) begin errors++; $display("[TB] FAIL mid_emit key_down: got %b expected 0", bus.key_down); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int f = 0; f < 4; f++) begin
      m = (f < 2) ? 16'h0040 : 16'h0000;
      model_expect();
      drive_frame(m, 1'b0);
      for (int i = 0; i < FRAME; i++) begin
        checks += 2;
        if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL post_emit keyout f%0d c%0d: got %0d expected %0d", f, i, obs_key[i], exp_key[i]); end
        if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL post_emit key_down f%0d c%0d: got %b expected %b", f, i, obs_down[i], exp_down[i]); end
        if (obs_key[i] != 5'd31) emits++;
      end
      model_advance(ref_code(m, 1'b0));
    end
    checks++;
    if (emits != 0) begin errors++; $display("[TB] FAIL post_emit emit_count: got %0d expected 0", emits); end
  endtask

  task automatic test_random();
    logic [15:0] m = '0;
    logic lk = 1'b0;
    int hold, a, b;
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin m = 16'h0001 << $urandom_range(0, 15); lk = 1'b0; end
        6: begin m = '0; lk = 1'b0; end
        7: begin m = 16'($urandom); lk = 1'b1; end
        8: begin
          a  = $urandom_range(0, 15);
          b  = (a + $urandom_range(1, 15)) % 16;
          m  = (16'h0001 << a) | (16'h0001 << b);
          lk = 1'b0;
        end
        default: ;
      endcase
      hold = $urandom_range(1, 5);
      for (int f = 0; f < hold; f++) begin
        model_expect();
        drive_frame(m, lk);
        for (int i = 0; i < FRAME; i++) begin
          checks += 3;
          if (obs_key[i] !== exp_key[i]) begin errors++; $display("[TB] FAIL random keyout r%0d f%0d c%0d: got %0d expected %0d", r, f, i, obs_key[i], exp_key[i]); end
          if (obs_down[i] !== exp_down[i]) begin errors++; $display("[TB] FAIL random key_down r%0d f%0d c%0d: got %b expected %b", r, f, i, obs_down[i], exp_down[i]); end
          if (obs_col[i] !== exp_col[i]) begin errors++; $display("[TB] FAIL random col_n r%0d f%0d c%0d: got %b expected %b", r, f, i, obs_col[i], exp_col[i]); end
        end
        model_advance(ref_code(m, lk));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_lock_priority();
    test_ghost();
    test_slide();
    test_reset_mid_debounce();
    test_reset_mid_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
